// File: rtl/ssd_bcd_driver_if.sv
// Bundle of display-side signals between the SSD debug bus and the seven-segment pins.
// master drives the binary value; slave (the driver) produces the pin levels and update pulse.
interface ssd_bcd_driver_if;
  logic [12:0] value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd;

  modport master (output value, input an, input seg, input dp, input upd);
  modport slave  (input value, output an, output seg, output dp, output upd);
endinterface

// File: rtl/ssd_bcd_driver.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a 4-digit multiplexed display.
// Define SSD_LZB_EN to blank leading zero digits.
module ssd_bcd_driver #(
  parameter int unsigned REFRESH_BITS = 18
) (
  input logic              clk,
  input logic              rst,
  ssd_bcd_driver_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e                  state_q, state_d;
  logic [12:0]             bin_q, bin_d;
  logic [15:0]             bcd_q, bcd_d;
  logic [3:0]              iter_q, iter_d;
  logic [15:0]             digits_q, digits_d;
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    upd_q, upd_d;

  logic [15:0]             bcd_adj;
  logic [1:0]              idx;
  logic [3:0]              nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Per-nibble add-3 without inter-nibble carry; values never exceed 9 before adjust.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign idx = cnt_q[REFRESH_BITS-1 -: 2];
  assign nib = digits_q[{idx, 2'b00} +: 4];

`ifdef SSD_LZB_EN
  logic [3:0] blank;
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
  end
`endif

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    upd_d    = 1'b0;
    cnt_d    = cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        bin_d   = bus.value;
        bcd_d   = 16'h0000;
        iter_d  = 4'd0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d  = {bcd_adj[14:0], bin_q[12]};
        bin_d  = {bin_q[11:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd12) state_d = StLoad;
      end
      StLoad: begin
        digits_d = bcd_q;
        upd_d    = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    an_d  = ~(4'b0001 << idx);
    seg_d = decode(nib);
`ifdef SSD_LZB_EN
    if (blank[idx]) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;
  assign bus.upd = upd_q;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Scoreboard bench for ssd_bcd_driver: a posedge model queues expected commits and scan codes,
// a negedge monitor compares pins, upd timing and committed digits.
module tb_ssd_bcd_driver;

  logic clk = 1'b0;
  logic rst;

  ssd_bcd_driver_if bus ();

  ssd_bcd_driver #(.REFRESH_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] bcd;
  } exp_t;

  exp_t        q[$];
  int          ecnt = 0;
  int          ph = 0;
  logic [3:0]  bcnt = 4'd0;
  logic [15:0] disp_model = 16'h0000;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] exp_bcd(input logic [12:0] v);
    case (v)
      13'd0:    exp_bcd = 16'h0000;
      13'd7:    exp_bcd = 16'h0007;
      13'd42:   exp_bcd = 16'h0042;
      13'd59:   exp_bcd = 16'h0059;
      13'd999:  exp_bcd = 16'h0999;
      13'd1000: exp_bcd = 16'h1000;
      13'd1234: exp_bcd = 16'h1234;
      13'd8191: exp_bcd = 16'h8191;
      default:  exp_bcd = 16'hFFFF;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [10:0] scan_exp(input logic [3:0] c, input logic [15:0] d);
    logic [1:0] k;
    logic [3:0] a;
    logic [6:0] s;
    k = c[3:2];
    a = ~(4'b0001 << k);
    s = seg_of(d[{k, 2'b00} +: 4]);
`ifdef SSD_LZB_EN
    if ((k == 2'd3 && d[15:12] == 4'd0) || (k == 2'd2 && d[15:8] == 8'd0) ||
        (k == 2'd1 && d[15:4] == 12'd0)) begin
      a = 4'b1111;
      s = 7'b1111111;
    end
`endif
    scan_exp = {a, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, ecnt);
    end
  endtask

  // Reference model: IDLE falls on every 15th edge after reset; commit lands 14 edges later.
  initial begin
    logic [10:0] o;
    forever begin
      @(posedge clk);
      ecnt = ecnt + 1;
      if (rst) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        bcnt    = 4'd0;
        ph      = 0;
      end else begin
        o       = scan_exp(bcnt, disp_model);
        exp_an  = o[10:7];
        exp_seg = o[6:0];
        bcnt    = bcnt + 4'd1;
        if (ph == 0) q.push_back('{due: ecnt + 14, bcd: exp_bcd(bus.value)});
        ph = (ph == 14) ? 0 : ph + 1;
      end
    end
  end

  initial begin
    logic exp_u;
    forever begin
      @(negedge clk);
      exp_u = !rst && (q.size() > 0) && (q[0].due == ecnt);
      check("an", 32'(bus.an), 32'(exp_an));
      check("seg", 32'(bus.seg), 32'(exp_seg));
      check("dp", 32'(bus.dp), 32'd1);
      check("upd", 32'(bus.upd), 32'(exp_u));
      if (rst) begin
        q.delete();
        disp_model = 16'h0000;
      end else if (exp_u) begin
        check("digits", 32'(dut.digits_q), 32'(q[0].bcd));
        disp_model = q[0].bcd;
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ph == 1) seen = 1'b1;
    end
    check("idle_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    bus.value = 13'd0;
    tick(3);
    rst = 1'b0;
    tick(20);

    bus.value = 13'd1234;
    tick(40);
    bus.value = 13'd8191;
    tick(35);

    // Value change mid-conversion only takes effect at the following IDLE.
    bus.value = 13'd1234;
    wait_idle();
    tick(4);
    bus.value = 13'd42;
    tick(35);

    // Reset sampled on the 7th SHIFT edge aborts the conversion.
    wait_idle();
    tick(6);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(35);

    bus.value = 13'd7;
    tick(35);
    bus.value = 13'd999;
    tick(35);
    bus.value = 13'd1000;
    tick(35);
    bus.value = 13'd59;
    tick(35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
